// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - FFT front-end scheduler: beat FIFO plus burst/gap frame sequencer
// Optional FRAME_STATS_EN adds the frames_done and aborted status outputs.
module fft_frame_sequencer #(
  parameter int WIDTH       = 8,
  parameter int FRAME_BEATS = 8,
  parameter int GAP         = 9,
  parameter int DEPTH       = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ce,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_ar,
  input  logic [WIDTH-1:0] in_ai,
  input  logic [WIDTH-1:0] in_br,
  input  logic [WIDTH-1:0] in_bi,
  output logic             valid_a,
  output logic [WIDTH-1:0] ar,
  output logic [WIDTH-1:0] ai,
  output logic             valid_b,
  output logic [WIDTH-1:0] br,
  output logic [WIDTH-1:0] bi,
  output logic             frame_start,
  output logic             busy
`ifdef FRAME_STATS_EN
  ,
  output logic [15:0]      frames_done,
  output logic             aborted
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(FRAME_BEATS);
  localparam int GW = $clog2(GAP + 1);
  localparam logic [CW-1:0] FB_CNT    = CW'(FRAME_BEATS);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_BEATS - 1);
  localparam logic [GW-1:0] LAST_GAP  = GW'(GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [CW-1:0]      count_q, count_d;
  logic [AW-1:0]      wr_q, rd_q;
  logic [4*WIDTH-1:0] mem_q [DEPTH];
  logic [4*WIDTH-1:0] data_q;
  logic               valid_q, start_q;
  logic               push, pop, first;

  assign in_ready    = (count_q < FULL_CNT);
  assign push        = in_valid && in_ready && !flush;
  assign valid_a     = valid_q;
  assign valid_b     = valid_q;
  assign {ar, ai, br, bi} = data_q;
  assign frame_start = start_q;
  assign busy        = (state_q != S_IDLE);

  // A frame only starts with all of its beats already buffered, so BURST never underflows.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    first   = 1'b0;
    if (flush) begin
      beat_d  = '0;
      gap_d   = '0;
      state_d = (state_q == S_IDLE) ? S_IDLE : S_GAP;
    end else if (ce) begin
      case (state_q)
        S_IDLE: begin
          if (count_q >= FB_CNT) begin
            pop     = 1'b1;
            first   = 1'b1;
            beat_d  = BW'(1);
            state_d = S_BURST;
          end
        end
        S_BURST: begin
          pop   = 1'b1;
          first = (beat_q == '0);
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = S_GAP;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
        S_GAP: begin
          if (gap_q == LAST_GAP) begin
            gap_d   = '0;
            state_d = (count_q >= FB_CNT) ? S_BURST : S_IDLE;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush) count_d = '0;
    else       count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      gap_q   <= '0;
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      count_q <= count_d;
      if (flush) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + AW'(1);
        if (pop)  rd_q <= rd_q + AW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_q] <= {in_ar, in_ai, in_br, in_bi};
  end

  // Data registers only load on a pop, so they hold the last beat between frames.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      valid_q <= 1'b0;
      start_q <= 1'b0;
      data_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      start_q <= 1'b0;
    end else if (ce) begin
      valid_q <= pop;
      start_q <= first;
      if (pop) data_q <= mem_q[rd_q];
    end
  end

`ifdef FRAME_STATS_EN
  logic [15:0] frames_q;
  logic        aborted_q;
  logic        last;

  assign last        = pop && (state_q == S_BURST) && (beat_q == LAST_BEAT);
  assign frames_done = frames_q;
  assign aborted     = aborted_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      frames_q  <= '0;
      aborted_q <= 1'b0;
    end else begin
      if (last && frames_q != 16'hFFFF) frames_q <= frames_q + 16'd1;
      if (flush && state_q == S_BURST)  aborted_q <= 1'b1;
    end
  end
`endif

endmodule
